// File: rtl/generic_pack.sv
// Shared types and constants for the D5M frame source: FSM state encoding,
// Bayer colour levels, LFSR seed and test-pattern select codes.
package generic_pack;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FSTART = 3'd1,
      ACTIVE = 3'd2,
      HBLANK = 3'd3,
      FEND   = 3'd4,
      VBLANK = 3'd5
   } d5m_state_t;

   localparam logic [11:0] BAYER_G = 12'h400;
   localparam logic [11:0] BAYER_R = 12'h800;
   localparam logic [11:0] BAYER_B = 12'h200;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   localparam logic [1:0] PAT_RAMP  = 2'd0;
   localparam logic [1:0] PAT_BAYER = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_LFSR  = 2'd3;

   // Counter width for a 0..n-1 count; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/d5m_pattern_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for the pseudo-random test
// pattern; built only when D5M_FRAME_GEN_LFSR_EN is defined.
module d5m_pattern_lfsr
   import generic_pack::*;
(
   input  logic        pixclk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] state
);

   logic [15:0] r_state;
   logic        w_feedback;

   assign w_feedback = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         r_state <= LFSR_SEED;
      end else if (load) begin
         r_state <= LFSR_SEED;
      end else if (advance) begin
         r_state <= {w_feedback, r_state[15:1]};
      end
   end

   assign state = r_state;

endmodule

// File: rtl/d5m_frame_gen.sv
// D5M sensor-side frame source: ifval/ilval/idata raster with programmable
// geometry and test patterns. Define D5M_FRAME_GEN_LFSR_EN for the LFSR pattern.
module d5m_frame_gen
   import generic_pack::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int ACT_COLS   = 64,
   parameter int ACT_ROWS   = 48,
   parameter int H_BLANK    = 16,
   parameter int V_BLANK    = 32,
   parameter int FV_LV      = 4
) (
   input  logic                  pixclk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [1:0]            pattern_sel,
   output logic                  ifval,
   output logic                  ilval,
   output logic [DATA_WIDTH-1:0] idata,
   output logic                  frame_done,
   output logic [15:0]           frame_count
);

   localparam int HV_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int PH_MAX = (HV_MAX > FV_LV) ? HV_MAX : FV_LV;
   localparam int COL_W  = cnt_width(ACT_COLS);
   localparam int ROW_W  = cnt_width(ACT_ROWS);
   localparam int CNT_W  = cnt_width(PH_MAX);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(ACT_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ACT_ROWS - 1);
   localparam logic [CNT_W-1:0] FV_LAST  = CNT_W'(FV_LV - 1);
   localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BLANK - 1);

   d5m_state_t            r_state, w_state_nxt;
   logic [COL_W-1:0]      r_col, w_col_nxt;
   logic [ROW_W-1:0]      r_row, w_row_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [1:0]            r_pat;
   logic                  w_start;
   logic [DATA_WIDTH-1:0] w_pix;
   logic [DATA_WIDTH-1:0] w_ramp;
   logic                  w_check;

   logic                  r_ifval, r_ilval, r_frame_done;
   logic [DATA_WIDTH-1:0] r_idata;
   logic [15:0]           r_frame_count;

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (enable) w_start = 1'b1;
         end
         FSTART: begin
            if (r_cnt == FV_LAST) begin
               w_state_nxt = ACTIVE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ACTIVE: begin
            if (r_col == COL_LAST) begin
               w_col_nxt   = '0;
               w_state_nxt = (r_row == ROW_LAST) ? FEND : HBLANK;
            end else begin
               w_col_nxt = r_col + COL_W'(1);
            end
         end
         HBLANK: begin
            if (r_cnt == HB_LAST) begin
               w_state_nxt = ACTIVE;
               w_cnt_nxt   = '0;
               w_row_nxt   = r_row + ROW_W'(1);
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         FEND: begin
            if (r_cnt == FV_LAST) begin
               w_state_nxt = VBLANK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         VBLANK: begin
            if (r_cnt == VB_LAST) begin
               w_cnt_nxt = '0;
               if (enable) w_start = 1'b1;
               else        w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Frame start (from IDLE or end of VBLANK) always clears the raster.
      if (w_start) begin
         w_state_nxt = FSTART;
         w_col_nxt   = '0;
         w_row_nxt   = '0;
         w_cnt_nxt   = '0;
      end
   end

`ifdef D5M_FRAME_GEN_LFSR_EN
   logic [15:0] w_lfsr;

   d5m_pattern_lfsr u_lfsr (
      .pixclk  (pixclk),
      .reset   (reset),
      .load    (w_start),
      .advance (r_state == ACTIVE),
      .state   (w_lfsr)
   );
`endif

   assign w_ramp  = DATA_WIDTH'(32'(r_row) + 32'(r_col));
   assign w_check = 1'((32'(r_col) ^ 32'(r_row)) >> 3);

   always_comb begin
      w_pix = w_ramp;
      unique case (r_pat)
         PAT_BAYER: begin
            if (!r_row[0]) w_pix = r_col[0] ? DATA_WIDTH'(BAYER_R) : DATA_WIDTH'(BAYER_G);
            else           w_pix = r_col[0] ? DATA_WIDTH'(BAYER_G) : DATA_WIDTH'(BAYER_B);
         end
         PAT_CHECK: w_pix = w_check ? '1 : '0;
`ifdef D5M_FRAME_GEN_LFSR_EN
         PAT_LFSR:  w_pix = DATA_WIDTH'(w_lfsr);
`else
         PAT_LFSR:  w_pix = w_ramp;
`endif
         default:   w_pix = w_ramp;
      endcase
   end

   // Outputs are registered from the current state, so they trail the FSM by
   // one cycle and each state's dwell maps directly onto its output interval.
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_col         <= '0;
         r_row         <= '0;
         r_cnt         <= '0;
         r_pat         <= PAT_RAMP;
         r_ifval       <= 1'b0;
         r_ilval       <= 1'b0;
         r_idata       <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_cnt        <= w_cnt_nxt;
         if (w_start) r_pat <= pattern_sel;
         r_ifval      <= (r_state == FSTART) || (r_state == ACTIVE) ||
                         (r_state == HBLANK) || (r_state == FEND);
         r_ilval      <= (r_state == ACTIVE);
         r_idata      <= (r_state == ACTIVE) ? w_pix : '0;
         r_frame_done <= (r_state == VBLANK) && (r_cnt == '0);
         if ((r_state == VBLANK) && (r_cnt == '0)) r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign ifval       = r_ifval;
   assign ilval       = r_ilval;
   assign idata       = r_idata;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_d5m_frame_gen.sv
// Self-checking bench for d5m_frame_gen: directed frame sequence with a
// pixel table, plus randomized enable/pattern/reset against an offset-based model.
`timescale 1ns/1ps
module tb_d5m_frame_gen;

   localparam int DW   = 12;
   localparam int C    = 16;
   localparam int R    = 4;
   localparam int HB   = 2;
   localparam int VB   = 3;
   localparam int FV   = 1;
   localparam int LREG = R * C + (R - 1) * HB;
   localparam int FEND_END = 2 * FV + LREG;
   localparam int PER  = FEND_END + VB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    pattern_sel = 2'd0;
   logic          ifval, ilval, frame_done;
   logic [DW-1:0] idata;
   logic [15:0]   frame_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   d5m_frame_gen #(
      .DATA_WIDTH (DW),
      .ACT_COLS   (C),
      .ACT_ROWS   (R),
      .H_BLANK    (HB),
      .V_BLANK    (VB),
      .FV_LV      (FV)
   ) dut (
      .pixclk      (clk),
      .reset       (reset),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .ifval       (ifval),
      .ilval       (ilval),
      .idata       (idata),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic b;
      b = l[0] ^ l[2] ^ l[3] ^ l[5];
      return {b, l[15:1]};
   endfunction

   function automatic logic [DW-1:0] pix(input int pat, input int row, input int col,
                                         input logic [15:0] lf);
      int ramp;
      ramp = (row + col) % (1 << DW);
      case (pat)
         1: begin
            if (row % 2 == 0) return (col % 2 == 0) ? DW'(12'h400) : DW'(12'h800);
            else              return (col % 2 == 0) ? DW'(12'h200) : DW'(12'h400);
         end
         2: return (((col / 8) % 2) != ((row / 8) % 2)) ? {DW{1'b1}} : '0;
`ifdef D5M_FRAME_GEN_LFSR_EN
         3: return lf[DW-1:0];
`endif
         default: return DW'(ramp);
      endcase
   endfunction

   bit            m_run = 0;
   int            m_o = 0;
   int            m_pat = 0;
   logic [15:0]   m_lf = 16'hACE1;
   logic [15:0]   m_fc = '0;
   logic          e_ifval = 0, e_ilval = 0, e_done = 0;
   logic [DW-1:0] e_data = '0;
   bit            chk_en = 0;

   // Expected outputs after each edge, from the offset since frame start.
   always @(posedge clk or posedge reset) begin
      int p, q;
      if (reset) begin
         m_run = 0; m_o = 0; m_fc = '0;
         e_ifval = 0; e_ilval = 0; e_done = 0; e_data = '0;
      end else begin
         e_ifval = 0; e_ilval = 0; e_done = 0; e_data = '0;
         if (m_run) begin
            m_o++;
            if (m_o < FV) begin
               e_ifval = 1;
            end else if (m_o < FV + LREG) begin
               p = m_o - FV;
               q = p % (C + HB);
               e_ifval = 1;
               if (q < C) begin
                  e_ilval = 1;
                  e_data  = pix(m_pat, p / (C + HB), q, m_lf);
                  m_lf    = lfsr_next(m_lf);
               end
            end else if (m_o < FEND_END) begin
               e_ifval = 1;
            end else if (m_o == FEND_END) begin
               e_done = 1;
               m_fc   = m_fc + 16'd1;
            end
            if (m_o == PER - 1) begin
               if (enable) begin
                  m_o = -1; m_pat = int'(pattern_sel); m_lf = 16'hACE1;
               end else begin
                  m_run = 0;
               end
            end
         end else if (enable) begin
            m_run = 1; m_o = -1; m_pat = int'(pattern_sel); m_lf = 16'hACE1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en)
         check("scoreboard", {ifval, ilval, idata, frame_done, frame_count},
               {e_ifval, e_ilval, e_data, e_done, m_fc});
   end

   // ---------------- raster monitor ----------------
   int            cyc = 0;
   int            fv_rise[$];
   int            lv_rises = 0;
   int            cap_f = -1, cap_r = -1, cap_c = 0;
   int            lines [0:3] = '{0, 0, 0, 0};
   int            bad_pulse = 0;
   int            n_done = 0;
   logic          p_ifval = 0, p_ilval = 0;
   logic [DW-1:0] cap [0:3][0:R-1][0:C-1];

   always @(negedge clk) begin
      cyc++;
      if (ifval === 1'b1 && p_ifval === 1'b0) begin
         fv_rise.push_back(cyc);
         cap_f++;
         cap_r = -1;
      end
      if (ilval === 1'b1 && p_ilval === 1'b0) begin
         lv_rises++;
         cap_r++;
         cap_c = 0;
         if (cap_f >= 0 && cap_f < 4) lines[cap_f]++;
      end
      if (ilval === 1'b1) begin
         if (cap_f >= 0 && cap_f < 4 && cap_r >= 0 && cap_r < R && cap_c < C)
            cap[cap_f][cap_r][cap_c] = idata;
         cap_c++;
      end
      if (ilval === 1'b0 && p_ilval === 1'b1 && cap_c != C) bad_pulse++;
      if (frame_done === 1'b1) n_done++;
      p_ifval = ifval;
      p_ilval = ilval;
   end

   task automatic wait_rises(input int target, input int budget);
      int n = 0;
      while (lv_rises < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (lv_rises < target) check("timeout_wait_line", lv_rises, target);
      #1;
   endtask

   typedef struct {
      int          f;
      int          r;
      int          c;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_frames_stop, n_done_stop;
      bit did_rst;

      // Frame 0 ramp (pattern change in its row 1 must be ignored).
      vecs.push_back('{0, 0, 0,  12'h000});
      vecs.push_back('{0, 2, 0,  12'h002});
      vecs.push_back('{0, 2, 7,  12'h009});
      vecs.push_back('{0, 3, 8,  12'h00B});
      vecs.push_back('{0, 3, 15, 12'h012});
      // Frame 1 checkerboard.
      vecs.push_back('{1, 0, 0,  12'h000});
      vecs.push_back('{1, 0, 7,  12'h000});
      vecs.push_back('{1, 0, 8,  12'hFFF});
      vecs.push_back('{1, 3, 15, 12'hFFF});
      // Frame 2 Bayer GRBG.
      vecs.push_back('{2, 0, 0,  12'h400});
      vecs.push_back('{2, 0, 1,  12'h800});
      vecs.push_back('{2, 1, 0,  12'h200});
      vecs.push_back('{2, 1, 1,  12'h400});
      vecs.push_back('{2, 2, 3,  12'h800});
      vecs.push_back('{2, 3, 15, 12'h400});
      // Frame 3 pattern 3.
`ifdef D5M_FRAME_GEN_LFSR_EN
      vecs.push_back('{3, 0, 0,  12'hCE1});
      vecs.push_back('{3, 0, 1,  12'h670});
`else
      vecs.push_back('{3, 0, 0,  12'h000});
      vecs.push_back('{3, 0, 1,  12'h001});
      vecs.push_back('{3, 2, 5,  12'h007});
`endif

      // Reset held with enable high: outputs stay at reset values.
      reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0;
      repeat (5) begin
         @(negedge clk);
         check("reset_hold_outputs", {ifval, ilval, idata, frame_done, frame_count}, '0);
      end
      chk_en = 1;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ifval_after_edge1", ifval, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("ifval_after_edge2", ifval, 1'b1);

      // Directed four-frame run with mid-frame pattern changes, then stop.
      wait_rises(2, 2 * PER);  pattern_sel = 2'd2;
      wait_rises(6, 2 * PER);  pattern_sel = 2'd1;
      wait_rises(10, 2 * PER); pattern_sel = 2'd3;
      wait_rises(14, 2 * PER); enable = 1'b0;
      repeat (PER + 100) @(negedge clk);
      n_frames_stop = fv_rise.size();
      n_done_stop   = n_done;

      check("frames_before_stop", n_frames_stop, 4);
      check("frame_done_pulses", n_done_stop, 4);
      check("frame_count_after_stop", frame_count, 16'd4);
      check("ifval_idle_after_stop", ifval, 1'b0);
      check("bad_ilval_pulse_len", bad_pulse, 0);
      for (int f = 0; f < 4; f++) check($sformatf("lines_in_frame%0d", f), lines[f], R);
      for (int i = 0; i + 1 < 4 && i + 1 < fv_rise.size(); i++)
         check($sformatf("frame_period_%0d", i), fv_rise[i+1] - fv_rise[i], PER);

      foreach (vecs[i])
         check($sformatf("pix_f%0d_r%0d_c%0d", vecs[i].f, vecs[i].r, vecs[i].c),
               cap[vecs[i].f][vecs[i].r][vecs[i].c], vecs[i].exp);

      // Randomized enable / pattern activity with one reset mid-line.
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; enable = 1'b1;
      did_rst = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (reset) reset = 1'b0;
         if ($urandom_range(0, 49) == 0)  pattern_sel = 2'($urandom);
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         if (i > 1500 && !did_rst && ilval === 1'b1) begin
            did_rst = 1;
            reset = 1'b1;
            #1 check("reset_midline_clears", {ifval, ilval, idata, frame_done, frame_count}, '0);
         end
      end
      if (!did_rst) check("midline_reset_injected", did_rst, 1'b1);

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
